snn_uart_rx: RTL

- 8N1 UART receiver sitting directly upstream of the SNN input-image loader in the snn top level.
- Oversamples the asynchronous uart_rx pin with a baud-period counter, rejects false start bits, and assembles LSB-first bytes.
- Presents each byte with a rdy/clr_rdy handshake to the downstream consumer.
- Flags framing errors and overruns.

---
 rtl/snn_uart_rx.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/snn_uart_rx.sv
// 8N1 UART receiver feeding the SNN image loader.
// Mid-bit sampling, false-start rejection, rdy/clr_rdy handshake.
module snn_uart_rx #(
  parameter int BAUD_CNT = 2604,
  parameter int HALF_CNT = 1302
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  input  logic       clr_rdy,
  input  logic       clr_err,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  localparam logic [11:0] BAUD_LD = 12'(BAUD_CNT - 1);
  localparam logic [11:0] HALF_LD = 12'(HALF_CNT - 1);

  state_t      state;
  state_t      state_nx;
  logic        rx_meta;
  logic        rx_sync;
  logic        rx_prev;
  logic [11:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        tick;
  logic        fall;
  logic        load_half;
  logic        load_baud;
  logic        shift;
  logic        clr_bit;
  logic        deliver;
  logic        ferr_set;

  assign tick = (baud_cnt == 12'd0) && (state != IDLE);
  assign fall = !rx_sync && rx_prev;
  assign busy = (state != IDLE);

  always_comb begin
    state_nx  = state;
    load_half = 1'b0;
    load_baud = 1'b0;
    shift     = 1'b0;
    clr_bit   = 1'b0;
    deliver   = 1'b0;
    ferr_set  = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) begin
          load_half = 1'b1;
          state_nx  = START;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_sync) begin
            load_baud = 1'b1;
            clr_bit   = 1'b1;
            state_nx  = DATA;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift     = 1'b1;
          load_baud = 1'b1;
          if (bit_cnt == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (rx_sync) begin
            deliver  = 1'b1;
            state_nx = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_nx = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_sync) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      state   <= IDLE;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      state   <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      if (load_half)           baud_cnt <= HALF_LD;
      else if (load_baud)      baud_cnt <= BAUD_LD;
      else if (baud_cnt != 0)  baud_cnt <= baud_cnt - 12'd1;
      if (clr_bit)             bit_cnt <= '0;
      else if (shift)          bit_cnt <= bit_cnt + 3'd1;
      if (shift) shift_reg <= {rx_sync, shift_reg[7:1]};
    end
  end

  // Set always beats clear on the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (deliver) begin
        rx_data <= shift_reg;
        rdy     <= 1'b1;
      end else if (clr_rdy) begin
        rdy <= 1'b0;
      end
      if (deliver && rdy && !clr_rdy) overrun <= 1'b1;
      else if (clr_err)               overrun <= 1'b0;
      if (ferr_set)     frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

endmodule
